// File: rtl/mux2x1_arbiter.sv
// mux2x1_arbiter: two lane FIFOs feeding one registered output through a round-robin arbiter.
// Lanes accept a push per cycle; one word per cycle leaves, alternating between lanes under contention.
module mux2x1_arbiter_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  err
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;
    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(FIFO_DEPTH);
    // full is the pre-edge value, so a push to a full lane drops even if that lane pops now
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign head  = mem[rp];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
            if (push & full) err <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
endmodule

module mux2x1_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid0,
    input  logic [DATA_WIDTH-1:0] In0,
    input  logic                  valid1,
    input  logic [DATA_WIDTH-1:0] In1,
    input  logic                  pause,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sel,
    output logic                  empty0,
    output logic                  empty1,
    output logic                  full0,
    output logic                  full1,
    output logic                  err0,
    output logic                  err1
);
    logic [DATA_WIDTH-1:0] head0, head1;
    logic last_grant, grant, lane;
    mux2x1_arbiter_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(valid0), .din(In0), .pop(grant & ~lane),
        .head(head0), .empty(empty0), .full(full0), .err(err0)
    );
    mux2x1_arbiter_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(valid1), .din(In1), .pop(grant & lane),
        .head(head1), .empty(empty1), .full(full1), .err(err1)
    );
    // eligibility uses pre-edge emptiness, so a same-edge push is never bypassed
    assign grant = ~pause & (~empty0 | ~empty1);
    assign lane  = (~empty0 & ~empty1) ? ~last_grant : ~empty1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid   <= 1'b0;
            data_out   <= '0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            outValid <= grant;
            if (grant) begin
                data_out   <= lane ? head1 : head0;
                sel        <= lane;
                last_grant <= lane;
            end
        end
    end
endmodule

// File: doc/mux2x1_arbiter.md
MUX2X1_ARBITER -- requirements
Module: mux2x1_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each lane's data and of data_out.
REQ-002 Parameter: FIFO_DEPTH, 4, entries per lane FIFO; power of two only.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Port: valid0  input  1  lane 0 write request.
REQ-007 Port: In0  input  DATA_WIDTH  lane 0 write data.
REQ-008 Port: valid1  input  1  lane 1 write request.
REQ-009 Port: In1  input  DATA_WIDTH  lane 1 write data.
REQ-010 Port: pause  input  1  downstream stall; no pop while high.
REQ-011 Port: outValid  output  1  registered; data_out carries a popped word this cycle.
REQ-012 Port: data_out  output  DATA_WIDTH  registered output word.
REQ-013 Port: sel  output  1  registered; source lane of the current data_out word.
REQ-014 Port: empty0, empty1  output  1 each  lane FIFO empty (count==0).
REQ-015 Port: full0, full1  output  1 each  lane FIFO full (count==FIFO_DEPTH).
REQ-016 Port: err0, err1  output  1 each  sticky overflow flag per lane.

Function
REQ-017 Each lane has its own FIFO: write pointer, read pointer (log2(FIFO_DEPTH) bits, wrap FIFO_DEPTH-1 -> 0), and a count (log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH).
REQ-018 Push: validN=1 and fullN=0 at an edge -> InN written at write pointer, pointer advances.
REQ-019 Overflow: validN=1 and fullN=1 at an edge -> word dropped, FIFO unchanged, errN set to 1 and held until reset; full is evaluated on the pre-edge count, even if the same lane is popped on that edge.
REQ-020 Eligibility: lane N is eligible when emptyN=0 (pre-edge); a push arriving on the same edge is never popped on that edge (no bypass).
REQ-021 Arbiter state: single register last_grant (0 or 1); reset value 1 so lane 0 wins the first contention.
REQ-022 Grant rule, pause=0: both eligible -> grant lane != last_grant; exactly one eligible -> grant it; none eligible -> no grant.
REQ-023 On a grant: pop head of the granted lane; next cycle outValid=1, data_out=popped word, sel=granted lane; last_grant=granted lane.
REQ-024 No grant (pause=1 or none eligible): next cycle outValid=0; data_out, sel and last_grant hold their previous values.
REQ-025 Simultaneous push and pop on one lane: count unchanged, both pointers advance.
REQ-026 Latency: word pushed into an empty, uncontended lane at edge N appears on data_out with outValid=1 after edge N+1.
REQ-027 Throughput: one word per cycle total when pause=0 and at least one lane is eligible; under continuous two-lane backlog grants strictly alternate 0,1,0,1.
REQ-028 Per-lane ordering: words leave each lane in push order; no word is lost except per REQ-019.
REQ-029 Flags empty/full are derived combinationally from count; all other outputs are registers.

Reset
REQ-030 While reset=1, without waiting for a clock edge: outValid=0, data_out=0, sel=0, err0=err1=0, empty0=empty1=1, full0=full1=0.
REQ-031 While reset=1: all pointers and counts=0 and last_grant=1.
REQ-032 Reset asserted mid-operation discards all FIFO contents; no word pushed before reset is ever output afterward.
REQ-033 The first push is accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Single word: reset, then valid0=1, In0=0xA5 for one cycle -> one edge later outValid=1, data_out=0xA5, sel=0; the following cycle outValid=0.
REQ-035 Contention: push 0x10,0x11 on lane 0 and 0x20,0x21 on lane 1 on the same two edges -> output sequence 0x10(sel0), 0x20(sel1), 0x11(sel0), 0x21(sel1).
REQ-036 Overflow: pause=1, push 5 words 0x01..0x05 into lane 1 -> full1=1 after the 4th, err1=1 after the 5th; release pause -> output 0x01..0x04 only; err1 stays 1.
REQ-037 Pause: lane 0 holds 0x33, pause=1 for 3 cycles -> outValid=0, data_out holds its prior value; pause drops -> next cycle data_out=0x33, outValid=1.
REQ-038 Reset mid-stream: lane 0 holds 3 words, assert reset between edges -> outputs reach reset values immediately; after release with no pushes, outValid stays 0.
REQ-039 Pointer wrap: 10 words pushed and drained through lane 0 with pause=0 -> all 10 output in order; no err0.
